// File: rtl/gate_sweep_ctrl.sv
// Self-test sweep controller for the gate selector: passes user controls through when idle,
// otherwise walks every gate code and input combination, capturing and grading a truth table.
module gate_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_GATES     = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  user_in,
  input  logic [3:0]  user_sel,
  input  logic        gate_out,
  output logic [1:0]  sel_in,
  output logic [3:0]  sel_selection,
  output logic        busy,
  output logic        done,
  output logic [23:0] table_out,
  output logic [4:0]  err_count,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  // Expected nibbles XNOR..AND, gate g at bits [4g+3:4g]
  localparam logic [23:0] GOLDEN      = 24'h9617E8;
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  LAST_GATE   = 4'(NUM_GATES - 1);

  state_t      r_state;
  logic [3:0]  r_gate;
  logic [1:0]  r_combo;
  logic [7:0]  r_settle;
  logic        r_busy;
  logic        r_done;
  logic [23:0] r_table;
  logic [4:0]  r_err;
  logic        r_pass;

  logic [4:0]  w_bitIdx;
  logic        w_lastPoint;
  logic        w_mismatch;

  // gate < 6 always holds while sweeping, so {gate[2:0], combo} is 4*gate+combo
  assign w_bitIdx    = {r_gate[2:0], r_combo};
  assign w_lastPoint = (r_combo == 2'd3) && (r_gate == LAST_GATE);
  assign w_mismatch  = (gate_out != GOLDEN[w_bitIdx]);

  assign sel_in        = (r_state == IDLE) ? user_in  : r_combo;
  assign sel_selection = (r_state == IDLE) ? user_sel : r_gate;

  assign busy      = r_busy;
  assign done      = r_done;
  assign table_out = r_table;
  assign err_count = r_err;
  assign pass      = r_pass;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_gate   <= 4'd0;
      r_combo  <= 2'd0;
      r_settle <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_table  <= 24'd0;
      r_err    <= 5'd0;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_table  <= 24'd0;
            r_err    <= 5'd0;
            r_pass   <= 1'b0;
            r_gate   <= 4'd0;
            r_combo  <= 2'd0;
            r_settle <= SETTLE_LOAD;
            r_busy   <= 1'b1;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_settle == 8'd0) begin
            r_state <= SAMPLE;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        SAMPLE: begin
          // The sample is recorded even when abort arrives on the same edge
          r_table[w_bitIdx] <= gate_out;
          if (w_mismatch) begin
            r_err <= r_err + 5'd1;
          end
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_lastPoint) begin
            r_done  <= 1'b1;
            r_state <= FINISH;
          end else begin
            r_combo <= r_combo + 2'd1;
            if (r_combo == 2'd3) begin
              r_gate <= r_gate + 4'd1;
            end
            r_settle <= SETTLE_LOAD;
            r_state  <= SETTLE;
          end
        end
        FINISH: begin
          r_pass  <= (r_err == 5'd0);
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: a behavioural gate selector with injectable faults drives two
// controller instances; expected tables, counts and timings come from the sweep rules.
module tb_gate_sweep_ctrl;

  localparam int S1  = 2;
  localparam int NG1 = 6;
  localparam int S2  = 1;
  localparam int NG2 = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  userIn = 2'd0;
  logic [3:0]  userSel = 4'd0;
  logic        gateOut;
  logic [1:0]  selIn;
  logic [3:0]  selSelection;
  logic        busy;
  logic        done;
  logic [23:0] tableOut;
  logic [4:0]  errCount;
  logic        pass;

  logic        start2 = 1'b0;
  logic        gateOut2;
  logic [1:0]  selIn2;
  logic [3:0]  selSelection2;
  logic        busy2;
  logic        done2;
  logic [23:0] tableOut2;
  logic [4:0]  errCount2;
  logic        pass2;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] faultMask = 24'd0;
  int          stableCnt = 0;
  logic [5:0]  lastSel = 6'd0;
  logic [3:0]  nib1;
  logic [3:0]  nib2;

  gate_sweep_ctrl #(.SETTLE_CYCLES(S1), .NUM_GATES(NG1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .user_in(userIn), .user_sel(userSel), .gate_out(gateOut),
    .sel_in(selIn), .sel_selection(selSelection), .busy(busy), .done(done),
    .table_out(tableOut), .err_count(errCount), .pass(pass)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(S2), .NUM_GATES(NG2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .abort(1'b0),
    .user_in(2'd0), .user_sel(4'd0), .gate_out(gateOut2),
    .sel_in(selIn2), .sel_selection(selSelection2), .busy(busy2), .done(done2),
    .table_out(tableOut2), .err_count(errCount2), .pass(pass2)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] goldenNibble(input int g);
    case (g)
      0: return 4'b1000;
      1: return 4'b1110;
      2: return 4'b0111;
      3: return 4'b0001;
      4: return 4'b0110;
      5: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [23:0] goldenTable(input int ng);
    logic [23:0] t;
    t = 24'd0;
    for (int g = 0; g < ng; g++) t[4*g +: 4] = goldenNibble(g);
    return t;
  endfunction

  function automatic logic [23:0] lowBits(input int n);
    logic [23:0] m;
    m = 24'd0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Selector output is only trustworthy once its inputs have been stable for S1 cycles
  always @(negedge clk) begin
    if ({selSelection, selIn} != lastSel) begin
      lastSel   <= {selSelection, selIn};
      stableCnt <= 1;
    end else if (stableCnt < 1000) begin
      stableCnt <= stableCnt + 1;
    end
  end

  always_comb begin
    gateOut = 1'b0;
    nib1    = goldenNibble(int'(selSelection));
    if (selSelection < 4'd6)
      gateOut = nib1[selIn] ^ faultMask[{selSelection[2:0], selIn}] ^ (stableCnt < S1);
  end

  always_comb begin
    gateOut2 = 1'b0;
    nib2     = goldenNibble(int'(selSelection2));
    if (selSelection2 < 4'd6) gateOut2 = nib2[selIn2];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] mask, input logic withAbort);
    int k;
    int doneCnt;
    int doneAt;
    logic timedOut;
    logic [23:0] expTable;
    int expErr;
    faultMask = mask;
    start = 1'b1;
    abort = withAbort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    k = 0; doneCnt = 0; doneAt = -1; timedOut = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    while (1) begin
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
      if (k < 4*NG1*(S1+1)) begin
        userSel = 4'($urandom);
        userIn  = 2'($urandom);
        #1;
        checkOutput("sweep_sel", 32'({selSelection, selIn}),
                    32'({4'((k/(S1+1))/4), 2'((k/(S1+1))%4)}));
      end
      if (!busy) break;
      if (k >= 400) begin
        timedOut = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    expTable = goldenTable(NG1) ^ (mask & lowBits(4*NG1));
    expErr   = $countones(mask & lowBits(4*NG1));
    checkOutput("sweep_timeout", 32'(timedOut), 32'd0);
    checkOutput("done_cycle", 32'(doneAt + 1), 32'(4*NG1*(S1+1) + 1));
    checkOutput("done_pulses", 32'(doneCnt), 32'd1);
    checkOutput("busy_fall", 32'(k), 32'(doneAt + 1));
    checkOutput("table_out", 32'(tableOut), 32'(expTable));
    checkOutput("err_count", 32'(errCount), 32'(expErr));
    checkOutput("pass", 32'(pass), 32'(expErr == 0));
    checkOutput("user_mode_after", 32'({selSelection, selIn}), 32'({userSel, userIn}));
  endtask

  initial begin
    int doneEdges [3];
    int nd;
    int doneSeen;
    int abortEdge;
    logic [23:0] mask;

    userSel = 4'($urandom);
    userIn  = 2'($urandom);
    #13;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_table", 32'(tableOut), 32'd0);
    checkOutput("reset_err", 32'(errCount), 32'd0);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    checkOutput("reset_sel", 32'({selSelection, selIn}), 32'({userSel, userIn}));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    userSel = 4'd4;
    userIn  = 2'b01;
    #1;
    checkOutput("idle_passthrough", 32'({selSelection, selIn}), 32'({4'd4, 2'b01}));

    $display("[TB] golden sweep");
    applyStimulus(24'd0, 1'b0);

    $display("[TB] OR stuck at 0");
    applyStimulus(goldenTable(NG1) & 24'h0000F0, 1'b0);
    checkOutput("or_nibble", 32'(tableOut[7:4]), 32'd0);

    for (int r = 0; r < 3; r++) begin
      mask = 24'($urandom) & 24'($urandom) & 24'($urandom);
      $display("[TB] random fault mask %06h", mask);
      applyStimulus(mask, 1'b0);
    end

    $display("[TB] abort mid-sweep");
    mask = 24'($urandom) & 24'($urandom);
    faultMask = mask;
    abortEdge = 21;
    doneSeen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < abortEdge + 10; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (done) doneSeen++;
      if (k == abortEdge - 1) abort = 1'b1;
      if (k == abortEdge) begin
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
      end
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    checkOutput("abort_pass", 32'(pass), 32'd0);
    checkOutput("abort_table", 32'(tableOut),
                32'((goldenTable(NG1) ^ mask) & lowBits(abortEdge/(S1+1))));
    checkOutput("abort_err", 32'(errCount), 32'($countones(mask & lowBits(abortEdge/(S1+1)))));
    checkOutput("abort_user_mode", 32'({selSelection, selIn}), 32'({userSel, userIn}));

    $display("[TB] reset mid-sweep");
    faultMask = 24'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_table", 32'(tableOut), 32'd0);
    checkOutput("rst_err", 32'(errCount), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_sel", 32'({selSelection, selIn}), 32'({userSel, userIn}));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    applyStimulus(24'd0, 1'b1);

    $display("[TB] two-gate instance, start held");
    nd = 0;
    doneEdges = '{-1, -1, -1};
    start2 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 60; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (done2 && nd < 3) begin
        doneEdges[nd] = k;
        nd++;
      end
      if (k == 4*NG2*(S2+1) + 1) begin
        checkOutput("g2_busy_fall", 32'(busy2), 32'd0);
        checkOutput("g2_pass", 32'(pass2), 32'd1);
        checkOutput("g2_table", 32'(tableOut2), 32'(goldenTable(NG2)));
        checkOutput("g2_err", 32'(errCount2), 32'd0);
      end
      if (k == 4*NG2*(S2+1) + 2) begin
        checkOutput("g2_restart_busy", 32'(busy2), 32'd1);
        checkOutput("g2_restart_table", 32'(tableOut2), 32'd0);
        checkOutput("g2_restart_pass", 32'(pass2), 32'd0);
      end
      if (k == 39) start2 = 1'b0;
    end
    checkOutput("g2_done_count", 32'(nd), 32'd3);
    checkOutput("g2_done_first", 32'(doneEdges[0] + 1), 32'd17);
    checkOutput("g2_done_second", 32'(doneEdges[1] + 1), 32'(17 + 4*NG2*(S2+1) + 2));
    checkOutput("g2_idle_end", 32'(busy2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Controller that owns the selection/input ports of the abstract gate selector. When idle it passes the user's switch/key values straight through. On `start` it takes over and sweeps every combinational gate code (AND..XNOR, 0..5) across all four input combinations, samples `gate_out` after a settle delay, and builds a 24-bit truth table. It compares each sample against a built-in golden table and reports a mismatch count and a pass flag, giving the board a self-test mode for the gate datapath.

## Interface
- `SETTLE_CYCLES`, default 2: cycles the sweep drives each point before sampling; legal range 1..255.
- `NUM_GATES`, default 6: gate codes swept, 0..NUM_GATES-1; legal range 1..6.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level sampled in IDLE; high launches a sweep.
- `abort`  in  1  synchronous; high while busy ends the sweep early.
- `user_in`  in  2  manual gate inputs, from the inverted keys.
- `user_sel`  in  4  manual gate selection, from switches.
- `gate_out`  in  1  output of the gate selector.
- `sel_in`  out  2  drives the selector `in` port.
- `sel_selection`  out  4  drives the selector `selection` port.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `table_out`  out  24  captured truth table. Gate g occupies bits [4g+3:4g]. Bit index within the nibble is the input combination {in[1],in[0]}.
- `err_count`  out  5  number of samples that differed from the golden table.
- `pass`  out  1  high when the last completed sweep had err_count == 0.

## Operation
- Golden nibbles, gates 0..5: AND 4'b1000, OR 4'b1110, NAND 4'b0111, NOR 4'b0001, XOR 4'b0110, XNOR 4'b1001.
- Output mux: in IDLE, `sel_in` = `user_in` and `sel_selection` = `user_sel`, combinationally. In every other state they are driven from the registered sweep counters `gate` (4 bits) and `combo` (2 bits).
- States and transitions:
  - IDLE: on `start`, clear `table_out`, `err_count` and `pass`; set gate=0, combo=0; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: the point is driven. The counter decrements each cycle. When the counter is 0, go to SAMPLE.
  - SAMPLE: write `gate_out` to table_out[4*gate+combo]. If it differs from the golden bit, increment err_count. Then:
    - if combo==3 and gate==NUM_GATES-1, go to FINISH;
    - otherwise increment combo; on wrap 3->0, also increment gate. Reload the counter and go to SETTLE.
  - FINISH: assert `done` for this cycle only; register pass = (err_count==0); go to IDLE.
- `abort` in SETTLE or SAMPLE: go to IDLE next cycle.
  - No `done`; `pass` stays 0.
  - Partial `table_out` and `err_count` are held.
  - A SAMPLE coinciding with `abort` still records its bit.
- `abort` in FINISH has no effect; the sweep completes.
- `start` is ignored while busy. `start` and `abort` high together in IDLE: the sweep starts (abort is only meaningful while busy).
- `table_out`, `err_count` and `pass` hold until the next `start` or reset.
- err_count maximum is 24, so no saturation is needed.

## Timing
- Reset values: state IDLE, gate=0, combo=0, counter=0, busy=0, done=0, table_out=0, err_count=0, pass=0. `sel_*` follow the user inputs.
- Reset mid-sweep: immediate return to IDLE with all of the above values; control returns to the user combinationally.
- Counting from the edge that samples `start` as cycle 0:
  - busy rises at cycle 1.
  - Each point takes SETTLE_CYCLES+1 cycles (SETTLE_CYCLES in SETTLE, 1 in SAMPLE).
  - done is high at cycle 4*NUM_GATES*(SETTLE_CYCLES+1)+1. With defaults this is cycle 73.
  - busy falls the cycle after done.
- SETTLE_CYCLES=1: SETTLE lasts exactly one cycle per point.
- `gate_out` is sampled on the rising edge ending SAMPLE. The point being sampled has been stable on `sel_*` for at least SETTLE_CYCLES cycles at that edge.

## Test plan
- Golden selector, defaults, start pulse:
  - table_out == 24'h9_6_1_7_E_8 (XNOR..AND nibbles);
  - err_count == 0, pass == 1;
  - done is high for exactly one cycle, at cycle 73.
- Selector model with OR stuck at 0: err_count == 3, pass == 0, table_out[7:4] == 4'b0000.
- IDLE pass-through: user_sel=4'd4, user_in=2'b01 -> sel_selection=4, sel_in=01 in the same cycle. During a sweep, changes to user_* have no effect on sel_*.
- Abort at cycle 20 with defaults:
  - busy is low at cycle 21, done never fires, pass == 0;
  - table_out holds the bits of the first 7 points and is otherwise 0.
- Reset asserted mid-sweep, then released:
  - all outputs are 0 and the mux is in user mode;
  - a following start produces a full, correct sweep.
- NUM_GATES=2, SETTLE_CYCLES=1, start held high for 40 cycles:
  - done at cycle 17;
  - a second sweep starts on the IDLE cycle after done, clearing the results.
